// File: rtl/ws2812_frame_transmitter.sv
// WS2812 frame sequencer: resets the LED selector, fetches each GRB word and serialises it,
// then holds the line low to latch. Optional LED_AUTO_REFRESH_EN makes frames repeat forever.
module ws2812_frame_transmitter #(
    parameter int T0H_CYCLES   = 4,
    parameter int T1H_CYCLES   = 8,
    parameter int BIT_CYCLES   = 15,
    parameter int FETCH_CYCLES = 2,
    parameter int RESET_CYCLES = 3600
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        start,
    input  logic [23:0] led_data,
    input  logic        led_done,
    output logic        led_clock,
    output logic        led_counter_enabled,
    output logic        led_counter_reset,
    output logic        data_out,
    output logic        busy,
    output logic        frame_done
);

    localparam int CNT_W = 12;

    // Counter loads are "duration - 1"; a state ends on the cycle the counter reads zero.
    localparam logic [CNT_W-1:0] FETCH_LOAD = CNT_W'(FETCH_CYCLES - 1);
    localparam logic [CNT_W-1:0] LATCH_LOAD = CNT_W'(RESET_CYCLES - 1);
    localparam logic [CNT_W-1:0] T0H_LOAD   = CNT_W'(T0H_CYCLES - 1);
    localparam logic [CNT_W-1:0] T1H_LOAD   = CNT_W'(T1H_CYCLES - 1);
    localparam logic [CNT_W-1:0] T0L_LOAD   = CNT_W'(BIT_CYCLES - T0H_CYCLES - 1);
    localparam logic [CNT_W-1:0] T1L_LOAD   = CNT_W'(BIT_CYCLES - T1H_CYCLES - 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RESET_SEL,
        ST_FETCH,
        ST_HIGH,
        ST_LOW,
        ST_ADVANCE,
        ST_LATCH
    } state_t;

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [23:0]       shift_q, shift_d;
    logic [4:0]        bit_index_q, bit_index_d;
    logic              frame_done_d;

    always_comb begin
        state_d      = state_q;
        cnt_d        = (cnt_q != '0) ? cnt_q - CNT_W'(1) : '0;
        shift_d      = shift_q;
        bit_index_d  = bit_index_q;
        frame_done_d = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_RESET_SEL;
                    cnt_d   = '0;
                end
            end
            ST_RESET_SEL: begin
                state_d = ST_FETCH;
                cnt_d   = FETCH_LOAD;
            end
            ST_FETCH: begin
                if (cnt_q == '0) begin
                    if (led_done) begin
                        state_d = ST_LATCH;
                        cnt_d   = LATCH_LOAD;
                    end else begin
                        state_d     = ST_HIGH;
                        shift_d     = led_data;
                        bit_index_d = 5'd23;
                        cnt_d       = led_data[23] ? T1H_LOAD : T0H_LOAD;
                    end
                end
            end
            ST_HIGH: begin
                if (cnt_q == '0) begin
                    state_d = ST_LOW;
                    cnt_d   = shift_q[23] ? T1L_LOAD : T0L_LOAD;
                end
            end
            ST_LOW: begin
                if (cnt_q == '0) begin
                    if (bit_index_q != 5'd0) begin
                        // Next bit is shift_q[22]; it becomes the MSB after the shift.
                        state_d     = ST_HIGH;
                        shift_d     = {shift_q[22:0], 1'b0};
                        bit_index_d = bit_index_q - 5'd1;
                        cnt_d       = shift_q[22] ? T1H_LOAD : T0H_LOAD;
                    end else begin
                        state_d = ST_ADVANCE;
                        cnt_d   = '0;
                    end
                end
            end
            ST_ADVANCE: begin
                state_d = ST_FETCH;
                cnt_d   = FETCH_LOAD;
            end
            ST_LATCH: begin
                if (cnt_q == '0) begin
                    frame_done_d = 1'b1;
`ifdef LED_AUTO_REFRESH_EN
                    state_d = ST_RESET_SEL;
`else
                    state_d = ST_IDLE;
`endif
                    cnt_d = '0;
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // Outputs are decoded from the next state so they line up with the registered state.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q             <= ST_IDLE;
            cnt_q               <= '0;
            shift_q             <= '0;
            bit_index_q         <= '0;
            led_clock           <= 1'b0;
            led_counter_enabled <= 1'b0;
            led_counter_reset   <= 1'b0;
            data_out            <= 1'b0;
            busy                <= 1'b0;
            frame_done          <= 1'b0;
        end else begin
            state_q             <= state_d;
            cnt_q               <= cnt_d;
            shift_q             <= shift_d;
            bit_index_q         <= bit_index_d;
            led_clock           <= (state_d == ST_ADVANCE);
            led_counter_enabled <= (state_d != ST_IDLE);
            led_counter_reset   <= (state_d == ST_RESET_SEL);
            data_out            <= (state_d == ST_HIGH);
            busy                <= (state_d != ST_IDLE);
            frame_done          <= frame_done_d;
        end
    end

endmodule

// File: tb/tb_ws2812_frame_transmitter.sv
// Directed bench for ws2812_frame_transmitter with a behavioural LED selector model.
// Cycle n is the period after edge E(n-1), where E0 is the edge that samples start.
module tb_ws2812_frame_transmitter;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [23:0] led_data;
    logic        led_done;
    logic        led_clock;
    logic        led_counter_enabled;
    logic        led_counter_reset;
    logic        data_out;
    logic        busy;
    logic        frame_done;

    always #5 clk = ~clk;

    ws2812_frame_transmitter dut (
        .clock              (clk),
        .reset              (reset),
        .start              (start),
        .led_data           (led_data),
        .led_done           (led_done),
        .led_clock          (led_clock),
        .led_counter_enabled(led_counter_enabled),
        .led_counter_reset  (led_counter_reset),
        .data_out           (data_out),
        .busy               (busy),
        .frame_done         (frame_done)
    );

    // Selector model: counts num_leds-1 down to 0, done rises on the advance after index 0.
    int          num_leds = 150;
    logic        word_mode = 1'b0;
    logic [23:0] fixed_word = 24'h0;
    logic [7:0]  sel_count;
    logic        sel_done;

    always_ff @(posedge clk) begin
        if (reset) begin
            sel_count <= 8'd0;
            sel_done  <= 1'b0;
        end else if (led_counter_reset) begin
            sel_count <= 8'(num_leds - 1);
            sel_done  <= (num_leds == 0);
        end else if (led_clock && led_counter_enabled) begin
            if (sel_count == 8'd0) sel_done <= 1'b1;
            else                   sel_count <= sel_count - 8'd1;
        end
    end

    assign led_data = word_mode ? fixed_word : {16'h0, sel_count};
    assign led_done = sel_done;

    int n_cmp = 0;
    int n_mis = 0;

    int cyc, n_lclk, n_lrst, lrst_cyc, n_fdone, fdone_cyc;
    int n_bits, n_bad_high, n_p15, n_p18, n_pother, last_high_cyc, hi_len, last_rise;
    int bits_in_word;
    logic prev_do;
    logic [23:0] cur_word;
    logic [23:0] words[$];
    int hi_lens[$];
    int periods[$];

    task automatic check(input string tag, input longint obs, input longint exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_mis++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Pulses start at E0 and records the line until the n_frames-th frame_done,
    // the abort cycle (where reset is raised) or the cycle budget.
    task automatic run_frame(input int budget, input int restart_at, input int abort_at,
                             input int n_frames);
        n_lclk = 0; n_lrst = 0; lrst_cyc = 0; n_fdone = 0; fdone_cyc = 0;
        n_bits = 0; n_bad_high = 0; n_p15 = 0; n_p18 = 0; n_pother = 0;
        last_high_cyc = 0; hi_len = 0; last_rise = 0; bits_in_word = 0;
        prev_do = 1'b0; cur_word = '0;
        words.delete(); hi_lens.delete(); periods.delete();
        start = 1'b1;
        for (int c = 1; c <= budget; c++) begin
            @(negedge clk);
            cyc = c;
            start = (c == restart_at);
            if (led_clock) n_lclk++;
            if (led_counter_reset) begin n_lrst++; lrst_cyc = c; end
            if (frame_done) begin n_fdone++; fdone_cyc = c; end
            if (data_out) begin
                if (!prev_do) begin
                    if (last_rise > 0) begin
                        periods.push_back(c - last_rise);
                        if (c - last_rise == 15)      n_p15++;
                        else if (c - last_rise == 18) n_p18++;
                        else                          n_pother++;
                    end
                    last_rise = c;
                    hi_len = 0;
                end
                hi_len++;
                last_high_cyc = c;
            end else if (prev_do) begin
                hi_lens.push_back(hi_len);
                if (hi_len != 8 && hi_len != 4) n_bad_high++;
                cur_word = {cur_word[22:0], (hi_len == 8)};
                n_bits++;
                bits_in_word++;
                if (bits_in_word == 24) begin
                    words.push_back(cur_word);
                    bits_in_word = 0;
                end
            end
            prev_do = data_out;
            if (c == abort_at) begin
                check("abort_point_high", data_out, 1);
                reset = 1'b1;
                break;
            end
            if (frame_done && n_fdone == n_frames) break;
        end
        $display("run: cycles=%0d led_clock=%0d bits=%0d words=%0d frame_done@%0d",
                 cyc, n_lclk, n_bits, words.size(), fdone_cyc);
    endtask

    initial begin
        int order_err;
        int spurious;
        reset = 1'b1;
        start = 1'b0;
        repeat (5) @(negedge clk);
        check("reset_busy", busy, 0);
        check("reset_data_out", data_out, 0);
        reset = 1'b0;

        spurious = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (led_clock | led_counter_enabled | led_counter_reset | data_out | busy | frame_done)
                spurious++;
        end
        check("idle_outputs_quiet", spurious, 0);

`ifdef LED_AUTO_REFRESH_EN
        num_leds = 1; word_mode = 1'b1; fixed_word = 24'hA50000;
        run_frame(12000, 0, 0, 3);
        check("auto_frame_done_count", n_fdone, 3);
        check("auto_third_frame_done", fdone_cyc, 11899);
        check("auto_lrst_count", n_lrst, 3);
        check("auto_lrst_with_frame_done", lrst_cyc, fdone_cyc);
        check("auto_words", words.size(), 3);
        for (int i = 0; i < 3; i++) check("auto_word", words[i], 24'hA50000);
        check("auto_busy_stays", busy, 1);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("auto_reset_idle", busy, 0);
`else
        // Bit timing with a single fixed word.
        num_leds = 1; word_mode = 1'b1; fixed_word = 24'hA50000;
        run_frame(5000, 0, 0, 1);
        check("bt_first_high", hi_lens[0], 8);
        check("bt_first_low", periods[0] - hi_lens[0], 7);
        check("bt_second_high", hi_lens[1], 4);
        check("bt_second_low", periods[1] - hi_lens[1], 11);
        check("bt_bits", n_bits, 24);
        check("bt_period15", n_p15, 23);
        check("bt_word", words[0], 24'hA50000);
        check("bt_last_high", last_high_cyc, 352);
        check("bt_frame_done", fdone_cyc, 3967);
        check("bt_led_clock", n_lclk, 1);
        @(negedge clk);
        check("bt_frame_done_one_cycle", frame_done, 0);

        // Full 150-LED frame, index-valued data, a stray start at LED 50.
        word_mode = 1'b0; num_leds = 150;
        run_frame(60000, 18160, 0, 1);
        check("ff_lrst_count", n_lrst, 1);
        check("ff_lrst_cycle", lrst_cyc, 1);
        check("ff_led_clock", n_lclk, 150);
        check("ff_bits", n_bits, 3600);
        check("ff_bad_high", n_bad_high, 0);
        check("ff_period15", n_p15, 3450);
        check("ff_period18", n_p18, 149);
        check("ff_period_other", n_pother, 0);
        check("ff_last_high", last_high_cyc, 54439);
        check("ff_frame_done_count", n_fdone, 1);
        check("ff_frame_done_cycle", fdone_cyc, 58054);
        check("ff_words", words.size(), 150);
        order_err = 0;
        for (int i = 0; i < words.size(); i++)
            if (words[i] !== 24'(149 - i)) order_err++;
        check("ff_order", order_err, 0);
        spurious = 0;
        repeat (20) begin
            @(negedge clk);
            if (busy | frame_done | led_counter_reset) spurious++;
        end
        check("ff_no_requeue", spurious, 0);

        // Reset during bit 10 of the third LED (high phase, cycles 880..883).
        run_frame(2000, 0, 882, 1);
        check("rst_words_before", words.size(), 2);
        check("rst_word0", words[0], 149);
        check("rst_word1", words[1], 148);
        @(negedge clk);
        reset = 1'b0;
        check("rst_data_out", data_out, 0);
        check("rst_busy", busy, 0);
        spurious = 0;
        repeat (20) begin
            @(negedge clk);
            if (frame_done | led_clock | led_counter_reset | busy | data_out) spurious++;
        end
        check("rst_quiet", spurious, 0);

        // Restart after reset with a short strip.
        num_leds = 3;
        run_frame(6000, 0, 0, 1);
        check("rs_lrst_cycle", lrst_cyc, 1);
        check("rs_led_clock", n_lclk, 3);
        check("rs_frame_done", fdone_cyc, 4693);
        check("rs_word_first", words[0], 2);
        check("rs_word_last", words[2], 0);

        // Faulty selector (done at first fetch), start held in the frame_done cycle.
        num_leds = 0;
        run_frame(5000, 3604, 0, 1);
        check("fs_bits", n_bits, 0);
        check("fs_led_clock", n_lclk, 0);
        check("fs_frame_done", fdone_cyc, 3604);
        @(negedge clk);
        start = 1'b0;
        check("fs_restart_lrst", led_counter_reset, 1);
        check("fs_restart_busy", busy, 1);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
